// File: rtl/quiz_round_ctrl_if.sv
// Handshake and data bundle between the quiz sequencer, the player inputs,
// the question ROM and the score display.
interface quiz_round_ctrl_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              iStart;
    logic              iSubmit;
    logic [7:0]        iSW;
    logic [7:0]        iMemData;
    logic [ADDR_W-1:0] oAddr;
    logic [3:0]        oRU;
    logic [3:0]        oRD;
    logic              oHit;
    logic              oMiss;
    logic              oBusy;
    logic              oDone;

    modport master (
        output iStart, iSubmit, iSW, iMemData,
        input  oAddr, oRU, oRD, oHit, oMiss, oBusy, oDone
    );

    modport slave (
        input  iStart, iSubmit, iSW, iMemData,
        output oAddr, oRU, oRD, oHit, oMiss, oBusy, oDone
    );
endinterface

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the switch-versus-memory match game: walks the question
// ROM, collects one answer (or a timeout) per question and keeps a BCD hit score.
module quiz_round_ctrl #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned NUM_Q   = 10,
    parameter int unsigned TIMEOUT = 50000000
) (
    input logic             iClk,
    input logic             iRst,
    quiz_round_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_Q - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        ANSWER,
        CHECK,
        DONE
    } stateT;

    stateT             state, stateNext;
    logic [ADDR_W-1:0] addr, addrNext;
    logic [3:0]        ru, ruNext;
    logic [3:0]        rd, rdNext;
    logic              hit, hitNext;
    logic              miss, missNext;
    logic              busy, busyNext;
    logic              done, doneNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [7:0]        expVal, expNext;
    logic [7:0]        ansVal, ansNext;
    logic              forcedMiss, forcedNext;

    // State and output registers
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state      <= IDLE;
            addr       <= '0;
            ru         <= '0;
            rd         <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            expVal     <= '0;
            ansVal     <= '0;
            forcedMiss <= 1'b0;
        end else begin
            state      <= stateNext;
            addr       <= addrNext;
            ru         <= ruNext;
            rd         <= rdNext;
            hit        <= hitNext;
            miss       <= missNext;
            busy       <= busyNext;
            done       <= doneNext;
            cnt        <= cntNext;
            expVal     <= expNext;
            ansVal     <= ansNext;
            forcedMiss <= forcedNext;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext  = state;
        addrNext   = addr;
        ruNext     = ru;
        rdNext     = rd;
        hitNext    = 1'b0;
        missNext   = 1'b0;
        cntNext    = cnt;
        expNext    = expVal;
        ansNext    = ansVal;
        forcedNext = forcedMiss;

        case (state)
            IDLE, DONE: begin
                if (bus.iStart) begin
                    stateNext = FETCH;
                    addrNext  = '0;
                    ruNext    = '0;
                    rdNext    = '0;
                end
            end
            FETCH: stateNext = WAIT_MEM;
            WAIT_MEM: begin
                expNext    = bus.iMemData;
                cntNext    = '0;
                forcedNext = 1'b0;
                stateNext  = ANSWER;
            end
            ANSWER: begin
                // A submit in the final timeout cycle still counts as an answer
                if (bus.iSubmit) begin
                    ansNext    = bus.iSW;
                    forcedNext = 1'b0;
                    stateNext  = CHECK;
                end else if (cnt == LAST_CNT) begin
                    forcedNext = 1'b1;
                    stateNext  = CHECK;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            CHECK: begin
                if (!forcedMiss && (ansVal == expVal)) begin
                    hitNext = 1'b1;
                    if (ru == 4'd9) begin
                        if (rd != 4'd9) begin
                            ruNext = 4'd0;
                            rdNext = rd + 4'd1;
                        end
                    end else begin
                        ruNext = ru + 4'd1;
                    end
                end else begin
                    missNext = 1'b1;
                end
                if (addr == LAST_ADDR) begin
                    stateNext = DONE;
                end else begin
                    addrNext  = addr + ADDR_W'(1);
                    stateNext = FETCH;
                end
            end
            default: stateNext = IDLE;
        endcase

        busyNext = (stateNext != IDLE) && (stateNext != DONE);
        doneNext = (stateNext == DONE);
    end

    assign bus.oAddr = addr;
    assign bus.oRU   = ru;
    assign bus.oRD   = rd;
    assign bus.oHit  = hit;
    assign bus.oMiss = miss;
    assign bus.oBusy = busy;
    assign bus.oDone = done;
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl: drivers queue the expected pulse for
// each question, a negedge monitor pops and compares when oHit/oMiss fires.
module tb_quiz_round_ctrl;
    localparam int ADDR_W  = 4;
    localparam int NUM_Q   = 16;
    localparam int TIMEOUT = 8;

    logic iClk = 1'b0;
    logic iRst;

    quiz_round_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    quiz_round_ctrl #(
        .ADDR_W (ADDR_W),
        .NUM_Q  (NUM_Q),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .bus (bus)
    );

    always #5 iClk = ~iClk;

    // Synchronous question ROM
    logic [7:0] rom [NUM_Q];
    always @(posedge iClk) bus.iMemData <= rom[bus.oAddr];

    int cycCnt = 0;
    always @(posedge iClk) cycCnt = cycCnt + 1;

    typedef struct {
        logic              hit;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        ru;
        logic [3:0]        rd;
        logic              done;
        int                cyc;
    } expT;

    expT sbq[$];
    int  nCmp = 0;
    int  nErr = 0;
    int  score = 0;
    int  qIdx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycCnt);
        end
    endtask

    // Monitor: every hit/miss pulse must match the head of the scoreboard
    always @(negedge iClk) begin
        expT e;
        if (iRst === 1'b1 && (bus.oHit === 1'b1 || bus.oMiss === 1'b1)) begin
            if (sbq.size() == 0) begin
                nCmp++;
                nErr++;
                $display("FAIL unexpected_pulse: hit=%0b miss=%0b at cycle %0d, none expected",
                         bus.oHit, bus.oMiss, cycCnt);
            end else begin
                e = sbq.pop_front();
                chk("pulse_hit",   32'(bus.oHit),  32'(e.hit));
                chk("pulse_miss",  32'(bus.oMiss), 32'(!e.hit));
                chk("pulse_addr",  32'(bus.oAddr), 32'(e.addr));
                chk("pulse_ru",    32'(bus.oRU),   32'(e.ru));
                chk("pulse_rd",    32'(bus.oRD),   32'(e.rd));
                chk("pulse_done",  32'(bus.oDone), 32'(e.done));
                chk("pulse_cycle", 32'(cycCnt),    32'(e.cyc));
            end
        end
    end

    // Reference model: decimal score, saturating at 99
    task automatic pushExp(input logic isHit, input int cyc);
        expT e;
        if (isHit && score < 99) score++;
        e.hit  = isHit;
        e.ru   = 4'(score % 10);
        e.rd   = 4'(score / 10);
        e.done = (qIdx == NUM_Q - 1);
        e.addr = ADDR_W'(e.done ? qIdx : qIdx + 1);
        e.cyc  = cyc;
        sbq.push_back(e);
        if (!e.done) qIdx++;
    endtask

    // Called at a negedge in IDLE/DONE; returns at a negedge in ANSWER of question 0
    task automatic startRound();
        bus.iStart = 1'b1;
        @(negedge iClk);
        bus.iStart = 1'b0;
        score = 0;
        qIdx  = 0;
        repeat (2) @(negedge iClk);
    endtask

    // Called in ANSWER; returns in ANSWER of the next question
    task automatic submitQ(input logic [7:0] sw, input logic noisy);
        pushExp(sw == rom[qIdx], cycCnt + 2);
        bus.iSW     = sw;
        bus.iSubmit = 1'b1;
        @(negedge iClk);
        bus.iSubmit = noisy;
        bus.iSW     = ~sw;
        repeat (2) @(negedge iClk);
        bus.iSubmit = 1'b0;
        @(negedge iClk);
    endtask

    task automatic timeoutQ();
        pushExp(1'b0, cycCnt + TIMEOUT + 1);
        repeat (TIMEOUT + 3) @(negedge iClk);
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_addr"}, 32'(bus.oAddr), 32'd0);
        chk({tag, "_ru"},   32'(bus.oRU),   32'd0);
        chk({tag, "_rd"},   32'(bus.oRD),   32'd0);
        chk({tag, "_hit"},  32'(bus.oHit),  32'd0);
        chk({tag, "_miss"}, 32'(bus.oMiss), 32'd0);
        chk({tag, "_busy"}, 32'(bus.oBusy), 32'd0);
        chk({tag, "_done"}, 32'(bus.oDone), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycCnt);
        $fatal(1);
    end

    initial begin
        iRst        = 1'b0;
        bus.iStart  = 1'b0;
        bus.iSubmit = 1'b0;
        bus.iSW     = 8'h00;
        for (int i = 0; i < NUM_Q; i++) rom[i] = 8'(8'h10 + i);

        // Reset held with submit toggling, then idle with submit toggling
        repeat (3) begin
            @(negedge iClk);
            bus.iSubmit = ~bus.iSubmit;
        end
        checkAllZero("reset");
        iRst = 1'b1;
        repeat (4) begin
            @(negedge iClk);
            bus.iSubmit = ~bus.iSubmit;
        end
        bus.iSubmit = 1'b0;
        @(negedge iClk);
        checkAllZero("idle");

        // Round A: all 16 correct, with stray submits after question 5
        startRound();
        chk("a_busy", 32'(bus.oBusy), 32'd1);
        chk("a_addr", 32'(bus.oAddr), 32'd0);
        for (int i = 0; i < NUM_Q; i++) submitQ(rom[i], i == 5);
        chk("a_done",  32'(bus.oDone), 32'd1);
        chk("a_busy0", 32'(bus.oBusy), 32'd0);
        chk("a_addr",  32'(bus.oAddr), 32'd15);
        chk("a_ru",    32'(bus.oRU),   32'd6);
        chk("a_rd",    32'(bus.oRD),   32'd1);

        // Round B: timeout, wrong answer, ignored start, submit on last timeout cycle
        for (int i = 0; i < NUM_Q; i++) rom[i] = 8'hAA;
        startRound();
        chk("b_addr", 32'(bus.oAddr), 32'd0);
        chk("b_ru",   32'(bus.oRU),   32'd0);
        chk("b_rd",   32'(bus.oRD),   32'd0);
        chk("b_done", 32'(bus.oDone), 32'd0);
        timeoutQ();
        submitQ(8'h55, 1'b1);
        bus.iStart = 1'b1;
        @(negedge iClk);
        bus.iStart = 1'b0;
        submitQ(8'hAA, 1'b0);
        repeat (TIMEOUT - 1) @(negedge iClk);
        submitQ(8'hAA, 1'b0);
        chk("b_addr4", 32'(bus.oAddr), 32'd4);
        chk("b_ru2",   32'(bus.oRU),   32'd2);

        // Mid-round asynchronous reset
        iRst = 1'b0;
        #1;
        checkAllZero("midreset");
        chk("sb_empty_reset", 32'(sbq.size()), 32'd0);
        sbq.delete();
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);

        // Round C: mixed hits, misses and one timeout after the restart
        for (int i = 0; i < NUM_Q; i++) rom[i] = 8'(i * 3 + 1);
        startRound();
        chk("c_addr", 32'(bus.oAddr), 32'd0);
        chk("c_ru",   32'(bus.oRU),   32'd0);
        for (int i = 0; i < NUM_Q; i++) begin
            if (i == 7) timeoutQ();
            else submitQ((i % 3 == 0) ? rom[i] : (rom[i] ^ 8'h01), 1'b0);
        end
        chk("c_done", 32'(bus.oDone), 32'd1);
        chk("c_ru",   32'(bus.oRU),   32'd6);
        chk("c_rd",   32'(bus.oRD),   32'd0);

        repeat (3) @(negedge iClk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
Sequencer for the switch-versus-memory match game. It steps a synchronous question ROM through NUM_Q addresses and waits for the player to submit a switch value or time out. It compares the submitted value against the stored byte and keeps a two-digit BCD score of hits for the seven-segment digit drivers. It replaces the free-running comparator path with an explicit round/answer handshake.

Parameters:
ADDR_W, 4, width of ROM address.
NUM_Q, 10, questions per round (1..2^ADDR_W).
TIMEOUT, 50000000, iClk cycles allowed per answer (>=2).

Ports:
iClk  input  1  system clock, all state on rising edge.
iRst  input  1  asynchronous active-low reset.
iStart  input  1  single-cycle pulse; begins a round from IDLE or DONE.
iSubmit  input  1  single-cycle (pre-debounced) pulse; player commits iSW.
iSW  input  8  player answer switches.
iMemData  input  8  ROM read data, valid one cycle after oAddr is presented.
oAddr  output  ADDR_W  ROM address (current question index).
oRU  output  4  score units digit, BCD.
oRD  output  4  score tens digit, BCD.
oHit  output  1  one-cycle pulse: answer correct.
oMiss  output  1  one-cycle pulse: answer wrong or timed out.
oBusy  output  1  high in any state except IDLE and DONE.
oDone  output  1  high while in DONE.

Behaviour:
- Reset (iRst=0, async): state IDLE; oAddr=0, oRU=0, oRD=0, oHit=0, oMiss=0, oBusy=0, oDone=0; timeout counter and latched expected/answer registers = 0.
- All outputs registered; no combinational input-to-output paths.
- States: IDLE, FETCH, WAIT_MEM, ANSWER, CHECK, DONE.
- IDLE: iStart=1 -> FETCH; oAddr<=0, oRU<=0, oRD<=0.
- FETCH: one cycle, ROM samples oAddr -> WAIT_MEM.
- WAIT_MEM: latch iMemData into expected reg; clear timeout counter -> ANSWER.
- ANSWER: counter increments each cycle.
  - iSubmit=1: latch iSW -> CHECK (normal answer).
  - No submit and counter==TIMEOUT-1: -> CHECK with forced miss.
  - Submit and timeout in the same cycle: submit wins.
- CHECK (one cycle): hit = (answer==expected) and not forced miss.
  - On hit, BCD increment: oRU 9->0 with oRD+1; at 99 saturate (no change).
  - oHit or oMiss asserted for exactly the next cycle.
  - If oAddr==NUM_Q-1 -> DONE, else oAddr<=oAddr+1 -> FETCH.
- DONE: oDone=1; score held; iStart=1 -> FETCH with score and oAddr cleared, same as IDLE.
- iStart in any busy state: ignored.
- iSubmit outside ANSWER (including FETCH/WAIT_MEM/CHECK): ignored, not queued.
- Latency: iStart edge k -> oAddr=0 valid cycle k+1, ANSWER entered at k+3. Submit sampled at edge j -> score updated and oHit/oMiss high in cycle j+2; next question in ANSWER at j+4.
- Reset asserted mid-round: immediate return to reset values; no pulse is emitted.
- Score width: oRU/oRD never leave 0..9.

Test Plan:
- Reset then idle: iRst low 3 cycles, toggle iSubmit -> all outputs 0, state stays IDLE, oBusy=0.
- Perfect round: ROM[i]=8'h10+i, NUM_Q=10, submit matching iSW each question -> 10 oHit pulses, final oRD=1, oRU=0, oDone=1, oAddr=9.
- Timeout: TIMEOUT=8, no submit on question 0 -> oMiss pulse 8 cycles after ANSWER entry, oAddr advances to 1, score unchanged.
- Submit coinciding with last timeout cycle with correct iSW -> oHit, not oMiss; oRU increments.
- BCD wrap/saturate: preload via 99 hits across rounds with NUM_Q=16 (score cleared per round, so use 7 consecutive rounds not possible) -> instead force ROM all 8'hAA, NUM_Q=16, run 16 hits -> oRD=1, oRU=6; then a separate 9->10 check at hit 10 -> oRU=0, oRD=1 in the same cycle.
- Mid-round reset and restart: assert iRst at question 4 -> outputs 0 asynchronously; iStart afterwards -> oAddr=0, score 0, normal round; iStart pulsed during ANSWER -> ignored.
